// File: rtl/oddr_pkg.sv
// Shared types and constants for the ODDR pair feeder.
package oddr_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_PRBS7  = 2'd1,
    MODE_WORD   = 2'd2,
    MODE_IDLE   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // x^7 + x^6 + 1: feedback taken from bits 6 and 5 of the LFSR.
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  // One LFSR step's feedback bit (also the emitted PRBS bit).
  function automatic logic prbs7_fb(input logic [6:0] l);
    return ^(l & PRBS7_TAPS);
  endfunction

endpackage

// File: rtl/oddr_prbs7_2x.sv
// PRBS7 generator advancing two steps per clock; bits[1] is the earlier bit.
module oddr_prbs7_2x
  import oddr_pkg::*;
#(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [1:0] bits
);

  logic [6:0] lfsr;
  logic [6:0] lfsr_one;
  logic       fb_first;
  logic       fb_second;

  // Feedback for the two chained steps taken from the current LFSR value.
  always_comb begin
    fb_first  = prbs7_fb(lfsr);
    lfsr_one  = {lfsr[5:0], fb_first};
    fb_second = prbs7_fb(lfsr_one);
    bits      = {fb_first, fb_second};
  end

  // LFSR register: reload the seed on request, otherwise advance two steps when told.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= {lfsr[4:0], fb_first, fb_second};
    end else begin
      lfsr <= lfsr;
    end
  end

endmodule

// File: rtl/oddr_pair_feeder.sv
// Upstream data stage for an ODDR: emits a registered (d_rise, d_fall) pair every clock
// from a toggle pattern, a PRBS7 stream or a handshaked word serializer.
module oddr_pair_feeder
  import oddr_pkg::*;
#(
  parameter int         WORD_W    = 16,
  parameter logic [6:0] PRBS_SEED = 7'h7F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              d_rise,
  output logic              d_fall,
  output logic              out_active,
  output logic              underrun,
  output logic              word_done
);

  localparam int PAIRS = WORD_W / 2;
  localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(PAIRS - 2);

  if (((WORD_W % 2) != 0) || (WORD_W < 4)) begin : g_bad_word_w
    $error("oddr_pair_feeder: WORD_W must be even and >= 4");
  end
  if (PRBS_SEED == 7'h00) begin : g_bad_seed
    $error("oddr_pair_feeder: PRBS_SEED must be nonzero");
  end

  state_t            state, state_nxt;
  mode_t             mode_r, mode_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy, busy_nxt;
  logic              rise_nxt, fall_nxt, active_nxt, underrun_nxt, done_nxt;

  logic              accept;
  logic [WORD_W-1:0] ser_shreg;
  logic [CNT_W-1:0]  ser_cnt;
  logic              ser_busy, ser_rise, ser_fall, ser_done, ser_dry;

  logic              prbs_load, prbs_step;
  logic [1:0]        prbs_bits;

  // busy marks a word pair on the outputs; cnt is the index of that pair.
  // Ready only depends on state and counter so a held word_valid cannot loop back.
  assign word_ready = (state == ST_RUN) && (mode_r == MODE_WORD) &&
                      (!busy || (cnt == CNT_LAST));
  assign accept     = word_ready && word_valid;
  assign prbs_load  = (state == ST_IDLE);

  oddr_prbs7_2x #(
    .SEED (PRBS_SEED)
  ) u_prbs (
    .clk  (clk),
    .rst  (rst),
    .load (prbs_load),
    .step (prbs_step),
    .bits (prbs_bits)
  );

  // Serializer next step: load a new word, shift the next pair, or run dry.
  always_comb begin
    ser_shreg = shreg;
    ser_cnt   = cnt;
    ser_busy  = 1'b0;
    ser_rise  = 1'b0;
    ser_fall  = 1'b0;
    ser_done  = 1'b0;
    ser_dry   = 1'b0;
    if (accept) begin
      ser_rise  = word_data[WORD_W-1];
      ser_fall  = word_data[WORD_W-2];
      ser_shreg = {word_data[WORD_W-3:0], 2'b00};
      ser_cnt   = {CNT_W{1'b0}};
      ser_busy  = 1'b1;
    end else if (busy && (cnt != CNT_LAST)) begin
      ser_rise  = shreg[WORD_W-1];
      ser_fall  = shreg[WORD_W-2];
      ser_shreg = {shreg[WORD_W-3:0], 2'b00};
      ser_cnt   = cnt + CNT_W'(1);
      ser_busy  = 1'b1;
      ser_done  = (cnt == CNT_PEN);
    end else begin
      ser_dry   = 1'b1;
    end
  end

  // FSM next state and next values of all output registers.
  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode_r;
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    busy_nxt     = busy;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    active_nxt   = 1'b0;
    underrun_nxt = 1'b0;
    done_nxt     = 1'b0;
    prbs_step    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (enable) begin
          mode_nxt  = mode_t'(mode);
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_nxt = (mode_r == MODE_WORD) ? ST_DRAIN : ST_IDLE;
        end else begin
          state_nxt = ST_RUN;
        end
        case (mode_r)
          MODE_TOGGLE: begin
            rise_nxt   = 1'b1;
            active_nxt = 1'b1;
          end
          MODE_PRBS7: begin
            rise_nxt   = prbs_bits[1];
            fall_nxt   = prbs_bits[0];
            active_nxt = 1'b1;
            prbs_step  = 1'b1;
          end
          MODE_WORD: begin
            shreg_nxt    = ser_shreg;
            cnt_nxt      = ser_cnt;
            busy_nxt     = ser_busy;
            rise_nxt     = ser_rise;
            fall_nxt     = ser_fall;
            done_nxt     = ser_done;
            active_nxt   = !ser_dry;
            underrun_nxt = ser_dry && enable;
          end
          MODE_IDLE: begin
            active_nxt = 1'b1;
          end
          default: begin
            active_nxt = 1'b0;
          end
        endcase
      end
      ST_DRAIN: begin
        // word_ready is low here, so the serializer only finishes the word in flight.
        shreg_nxt  = ser_shreg;
        cnt_nxt    = ser_cnt;
        busy_nxt   = ser_busy;
        rise_nxt   = ser_rise;
        fall_nxt   = ser_fall;
        done_nxt   = ser_done;
        active_nxt = !ser_dry;
        if (ser_dry) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, serializer and output registers; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_r     <= MODE_TOGGLE;
      shreg      <= {WORD_W{1'b0}};
      cnt        <= {CNT_W{1'b0}};
      busy       <= 1'b0;
      d_rise     <= 1'b0;
      d_fall     <= 1'b0;
      out_active <= 1'b0;
      underrun   <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      mode_r     <= mode_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      d_rise     <= rise_nxt;
      d_fall     <= fall_nxt;
      out_active <= active_nxt;
      underrun   <= underrun_nxt;
      word_done  <= done_nxt;
    end
  end

endmodule
